// File: rtl/preamble_strip.sv
// preamble_strip: hunts an AXI-Stream for the preamble word, strips it and forwards the payload frame.
// Define PREAMBLE_STRIP_STATS_EN to build the frames_ok/frames_err/words_drop counters.
module preamble_strip #(
    parameter int          C_DATA_WIDTH       = 16,
    parameter int          C_FRAME_LEN        = 10,
    parameter logic [15:0] C_PREAMBLE_PATTERN = 16'hABCD
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    sync_o,
    output logic                    err_o,
    output logic [15:0]             frames_ok_o,
    output logic [15:0]             frames_err_o,
    output logic [15:0]             words_drop_o
);

    localparam int CW = $clog2(C_FRAME_LEN + 1);
    localparam logic [C_DATA_WIDTH-1:0] PATTERN = C_DATA_WIDTH'(C_PREAMBLE_PATTERN);
    localparam logic [CW-1:0] LEN = CW'(C_FRAME_LEN);

    typedef enum logic [1:0] {
        S_HUNT,
        S_DATA,
        S_DROP
    } state_e;

    state_e state_q, state_d;

    logic [CW-1:0]           cnt_q, cnt_d, cnt_inc;
    logic                    m_valid_q, m_valid_d;
    logic                    m_last_q, m_last_d;
    logic [C_DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                    err_q, err_d;
    logic                    hs_in, hs_out, is_pat, frame_full;

    assign hs_in      = s_axis_tvalid & s_axis_tready;
    assign hs_out     = m_valid_q & m_axis_tready;
    assign is_pat     = (s_axis_tdata == PATTERN);
    assign cnt_inc    = cnt_q + 1'b1;
    assign frame_full = (cnt_inc == LEN);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HUNT: begin
                if (hs_in && is_pat && !s_axis_tlast) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (hs_in) begin
                    if (s_axis_tlast) begin
                        state_d = S_HUNT;
                    end else if (frame_full) begin
                        state_d = S_DROP;
                    end
                end
            end
            S_DROP: begin
                if (hs_in && s_axis_tlast) begin
                    state_d = S_HUNT;
                end
            end
            default: state_d = S_HUNT;
        endcase
    end

    // Outside DATA the input is always accepted; the output register drains on its own.
    always_comb begin
        sync_o        = (state_q == S_DATA);
        s_axis_tready = (state_q == S_DATA) ? (~m_valid_q | m_axis_tready) : 1'b1;
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_data_d  = m_data_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        if (hs_out) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end
        case (state_q)
            S_HUNT: begin
                if (hs_in && is_pat) begin
                    cnt_d = '0;
                    err_d = s_axis_tlast;
                end
            end
            S_DATA: begin
                if (hs_in) begin
                    m_valid_d = 1'b1;
                    m_data_d  = s_axis_tdata;
                    m_last_d  = s_axis_tlast | frame_full;
                    cnt_d     = cnt_inc;
                    err_d     = ~s_axis_tlast & frame_full;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Data register is deliberately not cleared by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            m_data_q <= m_data_d;
        end
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign err_o         = err_q;

`ifdef PREAMBLE_STRIP_STATS_EN
    logic [15:0] ok_q, ok_d, ferr_q, ferr_d, drop_q, drop_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        ok_d   = ok_q;
        ferr_d = ferr_q;
        drop_d = drop_q;
        if (hs_in) begin
            case (state_q)
                S_HUNT: begin
                    if (!is_pat) drop_d = sat_inc(drop_q);
                end
                S_DATA: begin
                    if (s_axis_tlast) begin
                        ok_d = sat_inc(ok_q);
                    end else if (frame_full) begin
                        ferr_d = sat_inc(ferr_q);
                    end
                end
                S_DROP: drop_d = sat_inc(drop_q);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ok_q   <= '0;
            ferr_q <= '0;
            drop_q <= '0;
        end else begin
            ok_q   <= ok_d;
            ferr_q <= ferr_d;
            drop_q <= drop_d;
        end
    end

    assign frames_ok_o  = ok_q;
    assign frames_err_o = ferr_q;
    assign words_drop_o = drop_q;
`else
    assign frames_ok_o  = 16'h0;
    assign frames_err_o = 16'h0;
    assign words_drop_o = 16'h0;
`endif

endmodule

// File: tb/tb_preamble_strip.sv
// tb_preamble_strip: directed frames against a frame-level model of the preamble stripper.
// Stats expectations follow PREAMBLE_STRIP_STATS_EN.
`timescale 1ns/1ps
module tb_preamble_strip;

    localparam int          W   = 16;
    localparam int          LEN = 10;
    localparam logic [15:0] PAT = 16'hABCD;
`ifdef PREAMBLE_STRIP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam int M_HUNT = 0;
    localparam int M_DATA = 1;
    localparam int M_DROP = 2;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic [W-1:0] s_tdata = '0;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic         s_tlast = 1'b0;
    logic [W-1:0] m_tdata;
    logic         m_tvalid;
    logic         m_tready = 1'b1;
    logic         m_tlast;
    logic         sync_o, err_o;
    logic [15:0]  frames_ok, frames_err, words_drop;

    always #5 clk = ~clk;

    preamble_strip #(
        .C_DATA_WIDTH(W),
        .C_FRAME_LEN(LEN),
        .C_PREAMBLE_PATTERN(PAT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .s_axis_tdata(s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast),
        .sync_o(sync_o),
        .err_o(err_o),
        .frames_ok_o(frames_ok),
        .frames_err_o(frames_err),
        .words_drop_o(words_drop)
    );

    int vectors = 0;
    int errors  = 0;

    // Frame-level model
    int          m_st = M_HUNT;
    int          m_cnt = 0;
    logic [16:0] exp_q[$];
    logic        m_err_now = 1'b0;
    int          m_ok = 0, m_ferr = 0, m_drop = 0;

    logic [16:0] got_q[$];
    logic [16:0] lit_q[$];
    int          err_seen = 0;
    int          rdy_mode = 0;
    int          rdy_ph = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void model_word(input logic [15:0] d, input logic l);
        case (m_st)
            M_HUNT: begin
                if (d == PAT) begin
                    if (l) begin
                        m_err_now = 1'b1;
                    end else begin
                        m_st  = M_DATA;
                        m_cnt = 0;
                    end
                end else begin
                    m_drop++;
                end
            end
            M_DATA: begin
                m_cnt++;
                exp_q.push_back({l || (m_cnt == LEN), d});
                if (l) begin
                    m_ok++;
                    m_st = M_HUNT;
                end else if (m_cnt == LEN) begin
                    m_err_now = 1'b1;
                    m_ferr++;
                    m_st = M_DROP;
                end
            end
            default: begin
                m_drop++;
                if (l) m_st = M_HUNT;
            end
        endcase
    endfunction

    // Per-cycle compare against the model
    initial begin
        logic [16:0] item;
        forever begin
            @(negedge clk);
            check("valid", {31'd0, m_tvalid}, {31'd0, exp_q.size() != 0});
            check("sync", {31'd0, sync_o}, {31'd0, m_st == M_DATA});
            check("err", {31'd0, err_o}, {31'd0, m_err_now});
            if (sync_o)
                check("s_tready", {31'd0, s_tready}, {31'd0, !m_tvalid || m_tready});
            else
                check("s_tready_idle", {31'd0, s_tready}, 32'd1);
            check("frames_ok", {16'd0, frames_ok}, STATS ? m_ok : 0);
            check("frames_err", {16'd0, frames_err}, STATS ? m_ferr : 0);
            check("words_drop", {16'd0, words_drop}, STATS ? m_drop : 0);
            if (err_o === 1'b1) err_seen++;
            if (m_tvalid && m_tready) begin
                got_q.push_back({m_tlast, m_tdata});
                if (exp_q.size() != 0) begin
                    item = exp_q.pop_front();
                    check("out_word", {15'd0, m_tlast, m_tdata}, {15'd0, item});
                end
            end
            m_err_now = 1'b0;
            if (rst_i) begin
                exp_q.delete();
                m_st   = M_HUNT;
                m_cnt  = 0;
                m_ok   = 0;
                m_ferr = 0;
                m_drop = 0;
            end else if (s_tvalid && s_tready) begin
                model_word(s_tdata, s_tlast);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rdy_ph++;
            if (rdy_mode == 1) m_tready = (rdy_ph % 2 == 0);
        end
    end

    task automatic send(input logic [15:0] d, input logic l);
        int budget = 100;
        bit done = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        while (!done && budget > 0) begin
            @(negedge clk);
            done = s_tready;
            @(posedge clk);
            #1;
            budget--;
        end
        if (!done) begin
            vectors++;
            errors++;
            $display("FAIL send_timeout: word %h not accepted", d);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        int budget = 60;
        while ((exp_q.size() != 0 || m_tvalid) && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (budget == 0) begin
            vectors++;
            errors++;
            $display("FAIL drain_timeout: output not emptied");
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_got(input string name);
        check({name, "_count"}, got_q.size(), lit_q.size());
        for (int i = 0; i < lit_q.size() && i < got_q.size(); i++)
            check(name, {15'd0, got_q[i]}, {15'd0, lit_q[i]});
        got_q.delete();
        err_seen = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("rst_valid", {31'd0, m_tvalid}, 32'd0);
        check("rst_sync", {31'd0, sync_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_ok", {16'd0, frames_ok}, 32'd0);
        @(posedge clk);
        #1;

        // 1: basic frame
        send(PAT, 0); send(16'h0001, 0); send(16'h0002, 0); send(16'h0003, 1);
        drain();
        lit_q = '{17'h0_0001, 17'h0_0002, 17'h1_0003};
        check("t1_err_pulses", err_seen, 0);
        check_got("t1_out");
        check("t1_ok", {16'd0, frames_ok}, STATS ? 32'd1 : 32'd0);

        // 2: junk before preamble
        send(16'h1111, 0); send(16'h2222, 0);
        send(PAT, 0); send(16'h0005, 0); send(16'h0006, 1);
        drain();
        lit_q = '{17'h0_0005, 17'h1_0006};
        check_got("t2_out");
        check("t2_drop", {16'd0, words_drop}, STATS ? 32'd2 : 32'd0);

        // 3: overlong frame
        send(PAT, 0);
        for (int i = 1; i <= 12; i++) send(16'h0030 + 16'(i), i == 12);
        drain();
        lit_q.delete();
        for (int i = 1; i <= 10; i++) lit_q.push_back({i == 10, 16'h0030 + 16'(i)});
        check("t3_err_pulses", err_seen, 1);
        check_got("t3_out");
        check("t3_sync", {31'd0, sync_o}, 32'd0);
        check("t3_ferr", {16'd0, frames_err}, STATS ? 32'd1 : 32'd0);
        check("t3_drop", {16'd0, words_drop}, STATS ? 32'd4 : 32'd0);

        // 4: backpressure 1,0,1,0
        rdy_mode = 1;
        send(PAT, 0);
        for (int i = 1; i <= 6; i++) send(16'h0040 + 16'(i), i == 6);
        drain();
        rdy_mode = 0;
        m_tready = 1'b1;
        lit_q.delete();
        for (int i = 1; i <= 6; i++) lit_q.push_back({i == 6, 16'h0040 + 16'(i)});
        check_got("t4_out");
        check("t4_ok", {16'd0, frames_ok}, STATS ? 32'd3 : 32'd0);

        // 5: empty frame
        send(PAT, 1);
        drain();
        lit_q.delete();
        check("t5_err_pulses", err_seen, 1);
        check_got("t5_out");
        check("t5_sync", {31'd0, sync_o}, 32'd0);

        // 6: reset mid-frame with a word held in the output register
        send(PAT, 0); send(16'h0001, 0); send(16'h0002, 0);
        m_tready = 1'b0;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        m_tready = 1'b1;
        @(negedge clk);
        check("t6_valid", {31'd0, m_tvalid}, 32'd0);
        check("t6_sync", {31'd0, sync_o}, 32'd0);
        check("t6_ok_cleared", {16'd0, frames_ok}, 32'd0);
        @(posedge clk);
        #1;
        send(PAT, 0); send(16'h0007, 1);
        drain();
        lit_q = '{17'h0_0001, 17'h1_0007};
        check_got("t6_out");
        check("t6_ok", {16'd0, frames_ok}, STATS ? 32'd1 : 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
